// File: rtl/ram_arb_pkg.sv
// Shared encodings for the money RAM arbiter.
// Owner codes double as the external owner port value.
package ram_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INIT  = 2'd1,
        OWN_TRANS = 2'd2,
        OWN_DISP  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_arb_starve_counter.sv
// Counts display arbitration losses, saturating at LIMIT.
// Clear beats hold, hold beats increment.
module ram_arb_starve_counter
    import ram_arb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    assign at_limit = (count == LIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold && inc && !at_limit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Single owner of the money RAM port: init > trans > disp,
// with a forced display grant after repeated losses.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W       = 48,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_lock,
    input  logic              init_req,
    input  logic              init_addr,
    input  logic [DATA_W-1:0] init_wdata,
    output logic              init_done,
    input  logic              trans_req,
    input  logic              trans_we,
    input  logic              trans_addr,
    input  logic [DATA_W-1:0] trans_wdata,
    output logic              trans_done,
    input  logic              disp_req,
    input  logic              disp_addr,
    output logic              disp_done,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_wren,
    output logic              ram_access_type,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_result,
    output logic [1:0]        owner,
    output logic              busy
);

    localparam logic [1:0]       WAIT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e win;

    logic [1:0]        wait_q, wait_d;
    logic              wren_d, type_d;
    logic [DATA_W-1:0] data_d, rdata_d;
    logic              busy_d, fin;
    logic              trans_v, disp_v, disp_force;
    logic              starve_inc, starve_clr, starve_at_limit;
    logic [CNT_W-1:0]  starve_cnt;

    ram_arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .hold     (init_lock),
        .count    (starve_cnt),
        .at_limit (starve_at_limit)
    );

    assign owner = owner_q;

    // Winner of the IDLE decision; lock hides everyone but init.
    always_comb begin
        trans_v    = trans_req & ~init_lock;
        disp_v     = disp_req & ~init_lock;
        disp_force = disp_v && (starve_cnt == LIMIT_C);
        win        = OWN_NONE;
        if (init_req)        win = OWN_INIT;
        else if (disp_force) win = OWN_DISP;
        else if (trans_v)    win = OWN_TRANS;
        else if (disp_v)     win = OWN_DISP;
    end

    assign starve_inc = (state_q == S_IDLE) && disp_v &&
                        (win != OWN_DISP) && !starve_at_limit;
    assign starve_clr = (state_q == S_IDLE) && (win == OWN_DISP);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wren_d  = ram_wren;
        type_d  = ram_access_type;
        data_d  = ram_data_in;
        rdata_d = rdata;
        wait_d  = wait_q;
        fin     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win != OWN_NONE) begin
                    state_d = S_ISSUE;
                    owner_d = win;
                end
                case (win)
                    OWN_INIT: begin
                        wren_d = 1'b1;
                        type_d = init_addr;
                        data_d = init_wdata;
                    end
                    OWN_TRANS: begin
                        wren_d = trans_we;
                        type_d = trans_addr;
                        data_d = trans_wdata;
                    end
                    OWN_DISP: begin
                        wren_d = 1'b0;
                        type_d = disp_addr;
                        data_d = '0;
                    end
                    default: ;
                endcase
            end
            S_ISSUE: begin
                if (ram_wren) begin
                    state_d = S_DONE;
                    wren_d  = 1'b0;
                    fin     = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    rdata_d = ram_result;
                    fin     = 1'b1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_NONE;
            wait_q          <= '0;
            ram_wren        <= 1'b0;
            ram_access_type <= 1'b0;
            ram_data_in     <= '0;
            rdata           <= '0;
            init_done       <= 1'b0;
            trans_done      <= 1'b0;
            disp_done       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            wait_q          <= wait_d;
            ram_wren        <= wren_d;
            ram_access_type <= type_d;
            ram_data_in     <= data_d;
            rdata           <= rdata_d;
            init_done       <= fin && (owner_q == OWN_INIT);
            trans_done      <= fin && (owner_q == OWN_TRANS);
            disp_done       <= fin && (owner_q == OWN_DISP);
            busy            <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: vector table, corner sequences,
// and a randomized run against a transaction-level model.
module tb_ram_access_arbiter;

    localparam int RL  = 1;
    localparam int LIM = 8;
    localparam int DW  = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          init_lock = 1'b0;
    logic          init_req = 1'b0, init_addr = 1'b0;
    logic [DW-1:0] init_wdata = '0;
    logic          init_done;
    logic          trans_req = 1'b0, trans_we = 1'b0, trans_addr = 1'b0;
    logic [DW-1:0] trans_wdata = '0;
    logic          trans_done;
    logic          disp_req = 1'b0, disp_addr = 1'b0;
    logic          disp_done;
    logic [DW-1:0] rdata;
    logic          ram_wren, ram_access_type;
    logic [DW-1:0] ram_data_in, ram_result;
    logic [1:0]    owner;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_access_arbiter #(
        .DATA_W       (DW),
        .READ_LATENCY (RL),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .init_lock       (init_lock),
        .init_req        (init_req),
        .init_addr       (init_addr),
        .init_wdata      (init_wdata),
        .init_done       (init_done),
        .trans_req       (trans_req),
        .trans_we        (trans_we),
        .trans_addr      (trans_addr),
        .trans_wdata     (trans_wdata),
        .trans_done      (trans_done),
        .disp_req        (disp_req),
        .disp_addr       (disp_addr),
        .disp_done       (disp_done),
        .rdata           (rdata),
        .ram_wren        (ram_wren),
        .ram_access_type (ram_access_type),
        .ram_data_in     (ram_data_in),
        .ram_result      (ram_result),
        .owner           (owner),
        .busy            (busy)
    );

    // Two-word RAM with RL-cycle registered read.
    logic [DW-1:0] mem [2];
    logic [DW-1:0] pipe [RL];
    logic          ovr_en = 1'b0;
    logic [DW-1:0] ovr_val = '0;

    always @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            for (int i = 0; i < RL; i++) pipe[i] <= '0;
        end else begin
            if (ram_wren) mem[ram_access_type] <= ram_data_in;
            pipe[0] <= mem[ram_access_type];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign ram_result = ovr_en ? ovr_val : pipe[RL-1];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        init_lock = 1'b0;
        init_req = 1'b0;
        trans_req = 1'b0;
        disp_req = 1'b0;
        ovr_en = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        int          who;
        logic        we;
        logic        addr;
        logic [47:0] wdata;
        logic        ovr;
        logic [47:0] ovr_val;
        int          lat;
        logic [47:0] exp_rdata;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v, input int idx);
        int   done_k;
        int   wren_cnt;
        logic [1:0] own1;
        logic [2:0] which;
        logic [2:0] exp_which;
        logic       is_wr;
        is_wr = (v.who == 1) || (v.who == 2 && v.we);
        ovr_en = v.ovr;
        ovr_val = v.ovr_val;
        case (v.who)
            1: begin
                init_req = 1'b1; init_addr = v.addr; init_wdata = v.wdata;
            end
            2: begin
                trans_req = 1'b1; trans_we = v.we;
                trans_addr = v.addr; trans_wdata = v.wdata;
            end
            default: begin
                disp_req = 1'b1; disp_addr = v.addr;
            end
        endcase
        done_k = -1;
        wren_cnt = 0;
        own1 = 2'd0;
        which = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) own1 = owner;
            if (ram_wren) wren_cnt++;
            if ((init_done | trans_done | disp_done) && done_k < 0) begin
                done_k = k;
                which = {init_done, trans_done, disp_done};
                init_req = 1'b0;
                trans_req = 1'b0;
                disp_req = 1'b0;
            end
        end
        init_req = 1'b0;
        trans_req = 1'b0;
        disp_req = 1'b0;
        ovr_en = 1'b0;
        exp_which = (v.who == 1) ? 3'b100 : (v.who == 2) ? 3'b010 : 3'b001;
        check($sformatf("vec%0d_owner", idx), 64'(own1), 64'(v.who));
        check($sformatf("vec%0d_latency", idx), 64'(done_k), 64'(v.lat));
        check($sformatf("vec%0d_done_sel", idx), 64'(which), 64'(exp_which));
        check($sformatf("vec%0d_wren_cycles", idx), 64'(wren_cnt),
              64'(is_wr ? 1 : 0));
        check($sformatf("vec%0d_rdata", idx), 64'(rdata), 64'(v.exp_rdata));
    endtask

    // Transaction-level reference model state for the random run.
    int          free_at, m_start, m_done, scnt;
    logic [1:0]  m_owner;
    logic        m_write, m_addr;
    logic [47:0] m_wdata, m_rval, m_rdata;
    logic [47:0] model_mem [2];
    int          lock_left;

    function automatic logic [55:0] pack(input logic [1:0] o, input logic b,
        input logic w, input logic i, input logic t, input logic d,
        input logic [47:0] r);
        return {o, b, w, i, t, d, 1'b0, r};
    endfunction

    initial begin
        logic [2:0] order [$];
        int         multi, cnt, tcount;
        int         runs [$];
        logic [8:0] seq;
        logic [2:0] d;
        logic       act;
        logic [55:0] e_v, a_v;
        int         win;
        logic       tv, dv;

        vt[0] = '{2, 1'b1, 1'b1, 48'h000064_0000C8, 1'b0, 48'h0, 2,
                  48'h0};
        vt[1] = '{3, 1'b0, 1'b1, 48'h0, 1'b0, 48'h0, 2 + RL,
                  48'h000064_0000C8};
        vt[2] = '{3, 1'b0, 1'b0, 48'h0, 1'b1, 48'h00000A_000014, 2 + RL,
                  48'h00000A_000014};
        vt[3] = '{2, 1'b1, 1'b0, 48'h123456_789ABC, 1'b0, 48'h0, 2,
                  48'h00000A_000014};
        vt[4] = '{1, 1'b1, 1'b1, 48'h111111_222222, 1'b0, 48'h0, 2,
                  48'h00000A_000014};
        vt[5] = '{2, 1'b0, 1'b1, 48'h0, 1'b0, 48'h0, 2 + RL,
                  48'h111111_222222};
        vt[6] = '{2, 1'b1, 1'b0, 48'hABCDEF_012345, 1'b0, 48'h0, 2,
                  48'h111111_222222};
        vt[7] = '{3, 1'b0, 1'b0, 48'h0, 1'b0, 48'h0, 2 + RL,
                  48'hABCDEF_012345};
        vt[8] = '{3, 1'b0, 1'b1, 48'h0, 1'b1, 48'h5A5A5A_A5A5A5, 2 + RL,
                  48'h5A5A5A_A5A5A5};

        // Reset state, sampled while reset is still asserted.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_outputs",
              64'({owner, busy, ram_wren, init_done, trans_done,
                   disp_done, ram_access_type}), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));
        check("reset_data_in", 64'(ram_data_in), 64'(0));
        do_reset();

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // All three requesters at once.
        do_reset();
        init_req = 1'b1; init_addr = 1'b0; init_wdata = 48'h1;
        trans_req = 1'b1; trans_we = 1'b1; trans_addr = 1'b1;
        trans_wdata = 48'h2;
        disp_req = 1'b1; disp_addr = 1'b0;
        multi = 0;
        order.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            d = {init_done, trans_done, disp_done};
            if (d != 3'b000) begin
                order.push_back(d);
                if ($countones(d) > 1) multi++;
                if (d[2]) init_req = 1'b0;
                if (d[1]) trans_req = 1'b0;
                if (d[0]) disp_req = 1'b0;
            end
        end
        init_req = 1'b0; trans_req = 1'b0; disp_req = 1'b0;
        check("simul_done_count", 64'(order.size()), 64'(3));
        seq = (order.size() >= 3) ? {order[0], order[1], order[2]} : 9'h0;
        check("simul_order", 64'(seq), 64'(9'b100_010_001));
        check("simul_multi_done", 64'(multi), 64'(0));

        // init_lock masks trans and disp.
        do_reset();
        init_lock = 1'b1;
        trans_req = 1'b1; trans_we = 1'b0; trans_addr = 1'b1;
        disp_req = 1'b1; disp_addr = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (owner != 2'd0 || busy) cnt++;
        end
        check("lock_no_grant", 64'(cnt), 64'(0));
        init_lock = 1'b0;
        @(negedge clock);
        check("lock_release_owner", 64'(owner), 64'(2));
        order.delete();
        for (int k = 0; k < 20; k++) begin
            d = {init_done, trans_done, disp_done};
            if (d != 3'b000) begin
                order.push_back(d);
                if (d[1]) trans_req = 1'b0;
                if (d[0]) disp_req = 1'b0;
            end
            @(negedge clock);
        end
        trans_req = 1'b0; disp_req = 1'b0;
        seq = (order.size() >= 2) ? {3'b000, order[0], order[1]} : 9'h0;
        check("lock_release_order", 64'(seq), 64'(9'b000_010_001));

        // Starvation: trans and disp both held continuously.
        do_reset();
        trans_req = 1'b1; trans_we = 1'b1; trans_addr = 1'b0;
        trans_wdata = 48'h77;
        disp_req = 1'b1; disp_addr = 1'b0;
        tcount = 0;
        runs.delete();
        for (int k = 0; k < 100 && runs.size() < 2; k++) begin
            @(negedge clock);
            if (trans_done) tcount++;
            if (disp_done) begin
                runs.push_back(tcount);
                tcount = 0;
            end
        end
        trans_req = 1'b0; disp_req = 1'b0;
        check("starve_runs", 64'(runs.size()), 64'(2));
        check("starve_first", 64'(runs.size() > 0 ? runs[0] : -1), 64'(LIM));
        check("starve_second", 64'(runs.size() > 1 ? runs[1] : -1),
              64'(LIM));

        // Reset during the WAIT of a read.
        do_reset();
        repeat (2) @(negedge clock);
        run_vec(vt[8], 8);
        ovr_en = 1'b1;
        ovr_val = 48'h0F0F0F_F0F0F0;
        disp_req = 1'b1; disp_addr = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("midrst_in_wait", 64'({owner, busy}), 64'({2'd3, 1'b1}));
        reset = 1'b1;
        disp_req = 1'b0;
        @(negedge clock);
        check("midrst_state",
              64'({owner, busy, ram_wren, disp_done}), 64'(0));
        check("midrst_rdata", 64'(rdata), 64'(0));
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (disp_done || busy) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'(0));
        ovr_en = 1'b0;

        // Randomized run against the transaction-level model.
        do_reset();
        free_at = 0; m_start = -10; m_done = -10; scnt = 0;
        m_owner = 2'd0; m_write = 1'b0; m_addr = 1'b0;
        m_wdata = '0; m_rval = '0; m_rdata = '0;
        model_mem[0] = '0; model_mem[1] = '0;
        lock_left = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            act = (m_owner != 2'd0) && (k >= m_start + 1) && (k <= m_done);
            if (act && k == m_done && !m_write) m_rdata = m_rval;
            e_v = pack(act ? m_owner : 2'd0, act,
                       act && m_write && (k == m_start + 1),
                       act && k == m_done && m_owner == 2'd1,
                       act && k == m_done && m_owner == 2'd2,
                       act && k == m_done && m_owner == 2'd3, m_rdata);
            a_v = pack(owner, busy, ram_wren, init_done, trans_done,
                       disp_done, rdata);
            check("rnd_outputs", 64'(a_v), 64'(e_v));
            if (act && k == m_start + 1)
                check("rnd_issue",
                      64'({ram_access_type, m_write ? ram_data_in : 48'h0}),
                      64'({m_addr, m_write ? m_wdata : 48'h0}));

            if (init_done) init_req = 1'b0;
            else if (!init_req && $urandom_range(0, 99) < 3) init_req = 1'b1;
            if (trans_done) trans_req = 1'b0;
            else if (!trans_req && $urandom_range(0, 99) < 30)
                trans_req = 1'b1;
            if (disp_done) disp_req = 1'b0;
            else if (!disp_req && $urandom_range(0, 99) < 25)
                disp_req = 1'b1;
            if (lock_left > 0) lock_left--;
            else if ($urandom_range(0, 99) < 2)
                lock_left = $urandom_range(1, 8);
            init_lock = (lock_left > 0);
            init_addr = 1'($urandom);
            init_wdata = {16'($urandom), 32'($urandom)};
            trans_we = 1'($urandom);
            trans_addr = 1'($urandom);
            trans_wdata = {16'($urandom), 32'($urandom)};
            disp_addr = 1'($urandom);

            if (k >= free_at) begin
                tv = trans_req && !init_lock;
                dv = disp_req && !init_lock;
                if (init_req) win = 1;
                else if (dv && scnt == LIM) win = 3;
                else if (tv) win = 2;
                else if (dv) win = 3;
                else win = 0;
                if (win == 3) scnt = 0;
                else if (dv && scnt < LIM) scnt++;
                if (win != 0) begin
                    m_owner = 2'(win);
                    m_start = k;
                    m_write = (win == 1) || (win == 2 && trans_we);
                    m_addr = (win == 1) ? init_addr :
                             (win == 2) ? trans_addr : disp_addr;
                    m_wdata = (win == 1) ? init_wdata : trans_wdata;
                    if (m_write) model_mem[m_addr] = m_wdata;
                    else m_rval = model_mem[m_addr];
                    m_done = k + 2 + (m_write ? 0 : RL);
                    free_at = m_done + 1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Single owner of the 48-bit money RAM port (wren / access_type / data_in / result). It serialises accesses from three requesters: memory initialisation (write-only), transaction write-back/read from the memory controller, and the VGA money display (read-only). A sequencing FSM spaces each access to the RAM's read latency. A starvation guard ensures the display is still refreshed during long transaction bursts.

Parameters:
DATA_W, 48, RAM word width (two 24-bit player balances).
READ_LATENCY, 1, cycles from RAM address/issue to valid result; legal 1..3.
STARVE_LIMIT, 8, lost arbitrations by the display before it is force-granted; legal 1..15.

Ports:
clock  in  1  system clock (CLOCK_50).
reset  in  1  synchronous, active-high.
init_lock  in  1  while high only the init requester may be granted.
init_req  in  1  init write request (held until init_done).
init_addr  in  1  access_type for init write.
init_wdata  in  DATA_W  init write data.
init_done  out  1  one-cycle pulse: init write committed.
trans_req  in  1  transaction request.
trans_we  in  1  1 = write, 0 = read.
trans_addr  in  1  access_type for transaction.
trans_wdata  in  DATA_W  transaction write data.
trans_done  out  1  one-cycle pulse: transaction access complete.
disp_req  in  1  display read request.
disp_addr  in  1  access_type for display read.
disp_done  out  1  one-cycle pulse: display read complete.
rdata  out  DATA_W  last read result; valid from the done pulse until the next read completes.
ram_wren  out  1  to RAM wren.
ram_access_type  out  1  to RAM access_type.
ram_data_in  out  DATA_W  to RAM data_in.
ram_result  in  DATA_W  from RAM result.
owner  out  2  current grant: 0 none, 1 init, 2 trans, 3 disp.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, rdata 0. Reset wins over every other event.
- Mid-operation reset: ram_wren is low from the next edge and no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: requests are sampled only here. The winner is registered together with its ram_access_type, ram_data_in and ram_wren (1 for init, trans_we for trans, 0 for disp). If a winner exists, go to ISSUE; otherwise stay in IDLE.
- Priority: init > trans > disp.
  - Exception: if starve_cnt == STARVE_LIMIT and disp_req is high, disp wins over trans.
  - init_lock high masks trans_req and disp_req entirely; the starvation counter holds.
- Starvation counter: increments, saturating at STARVE_LIMIT, on each IDLE decision where disp_req=1 but disp loses. It clears when disp is granted.
- ISSUE, one cycle: RAM signals are stable. Then:
  - Write: go to DONE, and ram_wren drops at this edge.
  - Read: go to WAIT.
- WAIT: lasts READ_LATENCY cycles. rdata captures ram_result at the edge leaving WAIT.
- DONE, one cycle: the owner's done pulse is high; owner and busy remain valid. Next state is IDLE, with owner cleared.
- Latency, measured from the IDLE decision cycle t:
  - Write done at t+2.
  - Read done at t+2+READ_LATENCY.
  - Minimum back-to-back spacing: write every 3 cycles, read every 3+READ_LATENCY cycles.
- Requester rule: drop req in the cycle after done. If req is still high in IDLE, it is served again; this is legal and is not an error.
- Requester inputs (addr/wdata/we) are sampled only at the IDLE decision. Later changes do not affect an access already in flight.
- Simultaneous requests: exactly one grant; the losers simply remain pending.
- A trans write immediately followed by a disp read returns the written data. This holds because there is no reordering.

Decomposition:
- Shared package ram_arb_pkg:
  - owner encodings OWN_NONE/INIT/TRANS/DISP;
  - state encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE;
  - localparam CNT_W = 4.
- One sub-module, ram_arb_starve_counter:
  - inputs: inc, clr, hold;
  - output: saturating count and a limit flag.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset, then trans write (addr 1, wdata 48'h000064_0000C8) at t → ram_wren=1 only at t+1, trans_done at t+2, owner 2 during t+1..t+2.
- disp read, READ_LATENCY=1, with ram_result=48'h00000A_000014 → disp_done at t+3, rdata=48'h00000A_000014 and held through a following write.
- init_req, trans_req and disp_req all asserted in the same cycle → init served first, then trans, then disp; exactly one done pulse per access.
- init_lock=1 with trans_req and disp_req high for 20 cycles → no grant, owner stays 0; lock released → trans granted next.
- trans_req held continuously with disp_req high, STARVE_LIMIT=8 → disp granted on the 9th arbitration; counter returns to 0.
- reset asserted during WAIT of a read → next cycle: IDLE, busy=0, ram_wren=0, no disp_done; rdata=0.
